dmac_engine: RTL and testbench



---
 rtl/dmac_pkg.sv | 37 +++
 rtl/dmac_engine_if.sv | 62 ++++++
 rtl/dmac_buf.sv | 45 ++++
 rtl/dmac_engine.sv | 144 ++++++++++++++
 tb/tb_dmac_engine.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmac_pkg.sv
// Shared types, AXI constants and burst sizing for the DMA data mover.
package dmac_pkg;

    localparam int unsigned MAX_BEATS = 4;

    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StRreq,
        StRdata,
        StWreq,
        StWdata,
        StWresp
    } state_e;

    // Burst length in words. A burst stops at the remaining word count, the
    // buffer depth, and the next 4KB page of either address, whichever is
    // nearest. Offsets are the low 12 address bits; bits [1:0] are ignored.
    function automatic logic [2:0] calc_beats(input logic [13:0] remaining,
                                              input logic [11:0] src_off,
                                              input logic [11:0] dst_off);
        logic [13:0] beats;
        logic [13:0] room_src;
        logic [13:0] room_dst;
        beats    = 14'(MAX_BEATS);
        room_src = 14'd1024 - {4'd0, src_off[11:2]};
        room_dst = 14'd1024 - {4'd0, dst_off[11:2]};
        if (remaining < beats) beats = remaining;
        if (room_src < beats)  beats = room_src;
        if (room_dst < beats)  beats = room_dst;
        return beats[2:0];
    endfunction

endpackage

// File: rtl/dmac_engine_if.sv
// AXI4 master port of the DMA engine: AR, R, AW, W and B channels.
interface dmac_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              arvalid_o;
    logic              arready_i;
    logic [ADDR_W-1:0] araddr_o;
    logic [3:0]        arlen_o;
    logic [2:0]        arsize_o;
    logic [1:0]        arburst_o;

    logic              rvalid_i;
    logic              rready_o;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rlast_i;

    logic              awvalid_o;
    logic              awready_i;
    logic [ADDR_W-1:0] awaddr_o;
    logic [3:0]        awlen_o;
    logic [2:0]        awsize_o;
    logic [1:0]        awburst_o;

    logic              wvalid_o;
    logic              wready_i;
    logic [DATA_W-1:0] wdata_o;
    logic [3:0]        wstrb_o;
    logic              wlast_o;

    logic              bvalid_i;
    logic              bready_o;
    logic [1:0]        bresp_i;

    modport master (
        output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
        input  arready_i,
        input  rvalid_i, rdata_i, rresp_i, rlast_i,
        output rready_o,
        output awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
        input  awready_i,
        output wvalid_o, wdata_o, wstrb_o, wlast_o,
        input  wready_i,
        input  bvalid_i, bresp_i,
        output bready_o
    );

    modport slave (
        input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
        output arready_i,
        output rvalid_i, rdata_i, rresp_i, rlast_i,
        input  rready_o,
        input  awvalid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
        output awready_i,
        input  wvalid_o, wdata_o, wstrb_o, wlast_o,
        output wready_i,
        output bvalid_i, bresp_i,
        input  bready_o
    );

endinterface

// File: rtl/dmac_buf.sv
// Burst staging buffer: filled in order by read beats, drained in order by
// write beats. clr rewinds both indices at the start of each burst.
module dmac_buf #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  wr_idx,
    output logic [IDX_W-1:0]  rd_idx
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  wr_idx_q;
    logic [IDX_W-1:0]  rd_idx_q;

    // Storage and both indices; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else if (clr) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_idx_q] <= wr_data;
                wr_idx_q        <= wr_idx_q + 1'b1;
            end
            if (rd_en) rd_idx_q <= rd_idx_q + 1'b1;
        end
    end

    assign rd_data = mem_q[rd_idx_q];
    assign wr_idx  = wr_idx_q;
    assign rd_idx  = rd_idx_q;

endmodule

// File: rtl/dmac_engine.sv
// DMA data mover: copies byte_len/4 words from src to dst as read-burst /
// write-burst pairs of up to MAX_BEATS words, never crossing a 4KB page.
module dmac_engine
    import dmac_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  byte_len_i,
    input  logic              start_i,
    output logic              done_o,
    output logic              err_o,
    dmac_engine_if.master     axi
);

    localparam int unsigned WORDS_W = LEN_W - 2;
    localparam int unsigned IDX_W   = $clog2(MAX_BEATS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  src_q, dst_q;
    logic [WORDS_W-1:0] rem_q;
    logic [2:0]         beats_q;
    logic               err_q;

    logic [WORDS_W-1:0] words;
    logic [ADDR_W-1:0]  step, src_nxt, dst_nxt;
    logic [WORDS_W-1:0] rem_nxt;
    logic               rd_beat, wr_beat, last_rd, last_wr;
    logic [DATA_W-1:0]  buf_rd_data;
    logic [IDX_W-1:0]   buf_wr_idx, buf_rd_idx;

    assign words   = byte_len_i[LEN_W-1:2];
    assign step    = ADDR_W'({beats_q, 2'b00});
    assign src_nxt = src_q + step;
    assign dst_nxt = dst_q + step;
    assign rem_nxt = rem_q - WORDS_W'(beats_q);
    assign rd_beat = (state_q == StRdata) && axi.rvalid_i;
    assign wr_beat = (state_q == StWdata) && axi.wready_i;
    // The beat count, not rlast, closes a read burst.
    assign last_rd = (buf_wr_idx == IDX_W'(beats_q - 3'd1));
    assign last_wr = (buf_rd_idx == IDX_W'(beats_q - 3'd1));

    dmac_buf #(
        .DEPTH (MAX_BEATS),
        .DATA_W(DATA_W)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_q == StRreq),
        .wr_en  (rd_beat),
        .wr_data(axi.rdata_i),
        .rd_en  (wr_beat),
        .rd_data(buf_rd_data),
        .wr_idx (buf_wr_idx),
        .rd_idx (buf_rd_idx)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state: one read burst into the buffer, then one write burst out.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i && words != '0) state_d = StRreq;
            StRreq:  if (axi.arready_i) state_d = StRdata;
            StRdata: if (axi.rvalid_i && last_rd) state_d = StWreq;
            StWreq:  if (axi.awready_i) state_d = StWdata;
            StWdata: if (axi.wready_i && last_wr) state_d = StWresp;
            StWresp: if (axi.bvalid_i) state_d = (rem_nxt == '0) ? StIdle : StRreq;
            default: state_d = StIdle;
        endcase
    end

    // Transfer bookkeeping; beats is recomputed whenever RREQ is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == StIdle && start_i) begin
                err_q <= 1'b0;
                if (words != '0) begin
                    src_q   <= src_addr_i;
                    dst_q   <= dst_addr_i;
                    rem_q   <= words;
                    beats_q <= calc_beats(14'(words), src_addr_i[11:0], dst_addr_i[11:0]);
                end
            end
            if (rd_beat && axi.rresp_i != RESP_OKAY) err_q <= 1'b1;
            if (state_q == StWresp && axi.bvalid_i) begin
                if (axi.bresp_i != RESP_OKAY) err_q <= 1'b1;
                src_q   <= src_nxt;
                dst_q   <= dst_nxt;
                rem_q   <= rem_nxt;
                beats_q <= calc_beats(14'(rem_nxt), src_nxt[11:0], dst_nxt[11:0]);
            end
        end
    end

    // Channel valids/readies decoded from state.
    always_comb begin
        axi.arvalid_o = 1'b0;
        axi.rready_o  = 1'b0;
        axi.awvalid_o = 1'b0;
        axi.wvalid_o  = 1'b0;
        axi.bready_o  = 1'b0;
        unique case (state_q)
            StRreq:  axi.arvalid_o = 1'b1;
            StRdata: axi.rready_o  = 1'b1;
            StWreq:  axi.awvalid_o = 1'b1;
            StWdata: axi.wvalid_o  = 1'b1;
            StWresp: axi.bready_o  = 1'b1;
            default: ;
        endcase
    end

    assign axi.araddr_o  = {src_q[ADDR_W-1:2], 2'b00};
    assign axi.arlen_o   = {1'b0, beats_q} - 4'd1;
    assign axi.arsize_o  = SIZE_4B;
    assign axi.arburst_o = BURST_INCR;
    assign axi.awaddr_o  = {dst_q[ADDR_W-1:2], 2'b00};
    assign axi.awlen_o   = {1'b0, beats_q} - 4'd1;
    assign axi.awsize_o  = SIZE_4B;
    assign axi.awburst_o = BURST_INCR;
    assign axi.wdata_o   = buf_rd_data;
    assign axi.wstrb_o   = 4'hF;
    assign axi.wlast_o   = (state_q == StWdata) && last_wr;

    assign done_o = (state_q == StIdle);
    assign err_o  = err_q;

endmodule

// File: tb/tb_dmac_engine.sv
// Bench for dmac_engine: a randomly stalling AXI memory slave plus a
// word-level model of the expected burst list and destination contents.
module tb_dmac_engine;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  len;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] byte_len;
    logic        start;
    logic        done, err;

    always #5 clk = ~clk;

    dmac_engine_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    dmac_engine #(
        .ADDR_W(32),
        .DATA_W(32),
        .LEN_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_addr_i(src_addr),
        .dst_addr_i(dst_addr),
        .byte_len_i(byte_len),
        .start_i   (start),
        .done_o    (done),
        .err_o     (err),
        .axi       (axi)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int unsigned];  // word-indexed memory
    burst_t      ar_log[$];
    burst_t      aw_log[$];

    int          rd_left, wr_left, b_pending, r_beat_cnt, err_beat;
    logic [31:0] rd_addr, wr_addr;
    bit          r_taken, b_taken;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory slave: everything driven and sampled at negedge, so a
    // valid&&ready pair seen here completes at the following posedge.
    initial begin
        axi.arready_i = 1'b0; axi.awready_i = 1'b0; axi.wready_i = 1'b0;
        axi.rvalid_i  = 1'b0; axi.rdata_i   = '0;   axi.rresp_i  = '0;
        axi.rlast_i   = 1'b0; axi.bvalid_i  = 1'b0; axi.bresp_i  = '0;
        rd_left = 0; wr_left = 0; b_pending = 0; r_beat_cnt = 0; err_beat = -1;
        rd_addr = '0; wr_addr = '0; r_taken = 0; b_taken = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                axi.rvalid_i = 1'b0; axi.bvalid_i = 1'b0;
                rd_left = 0; wr_left = 0; b_pending = 0; r_taken = 0; b_taken = 0;
                continue;
            end
            if (r_taken) begin axi.rvalid_i = 1'b0; r_taken = 0; end
            if (!axi.rvalid_i && rd_left > 0 && $urandom_range(0, 3) != 0) begin
                axi.rvalid_i = 1'b1;
                axi.rdata_i  = mem.exists(rd_addr >> 2) ? mem[rd_addr >> 2] : 32'hBAD0_0000;
                axi.rresp_i  = (r_beat_cnt == err_beat) ? 2'b10 : 2'b00;
                axi.rlast_i  = (rd_left == 1);
            end
            if (b_taken) begin axi.bvalid_i = 1'b0; b_taken = 0; end
            if (!axi.bvalid_i && b_pending > 0 && $urandom_range(0, 2) != 0) begin
                axi.bvalid_i = 1'b1;
                axi.bresp_i  = 2'b00;
            end
            axi.arready_i = ($urandom_range(0, 2) != 0);
            axi.awready_i = ($urandom_range(0, 2) != 0);
            axi.wready_i  = ($urandom_range(0, 3) != 0);

            if (axi.arvalid_o && axi.arready_i) begin
                check("arsize", 64'(axi.arsize_o), 64'(3'b010));
                check("arburst", 64'(axi.arburst_o), 64'(2'b01));
                ar_log.push_back('{addr: axi.araddr_o, len: axi.arlen_o});
                rd_addr = axi.araddr_o;
                rd_left = int'(axi.arlen_o) + 1;
            end
            if (axi.rvalid_i && axi.rready_o) begin
                rd_left--; rd_addr += 32'd4; r_beat_cnt++; r_taken = 1;
            end
            if (axi.awvalid_o && axi.awready_i) begin
                check("awsize", 64'(axi.awsize_o), 64'(3'b010));
                check("awburst", 64'(axi.awburst_o), 64'(2'b01));
                aw_log.push_back('{addr: axi.awaddr_o, len: axi.awlen_o});
                wr_addr = axi.awaddr_o;
                wr_left = int'(axi.awlen_o) + 1;
            end
            if (axi.wvalid_o && axi.wready_i) begin
                check("wstrb", 64'(axi.wstrb_o), 64'(4'hF));
                check("wlast", 64'(axi.wlast_o), 64'(wr_left == 1));
                mem[wr_addr >> 2] = axi.wdata_o;
                wr_addr += 32'd4;
                wr_left--;
                if (wr_left == 0) b_pending++;
            end
            if (axi.bvalid_i && axi.bready_o) begin b_pending--; b_taken = 1; end
        end
    end

    // One complete copy, checked against a word-level model of the bursts.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                            input int ebeat, input string tag);
        burst_t      exp_ar[$];
        burst_t      exp_aw[$];
        logic [31:0] exp_data[$];
        burst_t      bt;
        int unsigned words, rem, b, room, sa, da, sw, dw;
        int          cyc;
        logic        busy, exp_err;
        words = 32'(len) >> 2;
        sw = s >> 2;
        dw = d >> 2;
        for (int i = 0; i < int'(words); i++) begin
            mem[sw + 32'(i)] = $urandom;
            exp_data.push_back(mem[sw + 32'(i)]);
        end
        for (int i = 0; i <= int'(words); i++) mem[dw + 32'(i)] = 32'hDEAD_BEEF;
        sa = s & ~32'h3;
        da = d & ~32'h3;
        rem = words;
        while (rem != 0) begin
            b = 4;
            if (rem < b) b = rem;
            room = (4096 - (sa % 4096)) / 4;
            if (room < b) b = room;
            room = (4096 - (da % 4096)) / 4;
            if (room < b) b = room;
            bt.len = 4'(b - 1);
            bt.addr = sa; exp_ar.push_back(bt);
            bt.addr = da; exp_aw.push_back(bt);
            sa += 4 * b; da += 4 * b; rem -= b;
        end
        exp_err = (ebeat >= 0) && (ebeat < int'(words));
        ar_log.delete(); aw_log.delete(); r_beat_cnt = 0; err_beat = ebeat;

        src_addr = s; dst_addr = d; byte_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " done after start"}, 64'(done), 64'(words == 0));
        busy = 1'b0;
        cyc = 0;
        if (words == 0) begin
            repeat (8) begin @(negedge clk); if (!done) busy = 1'b1; end
            check({tag, " stayed idle"}, 64'(busy), 64'(0));
        end else begin
            while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
            check({tag, " done within bound"}, 64'(cyc < 5000), 64'(1));
        end
        check({tag, " err"}, 64'(err), 64'(exp_err));
        check({tag, " ar count"}, 64'(ar_log.size()), 64'(exp_ar.size()));
        check({tag, " aw count"}, 64'(aw_log.size()), 64'(exp_aw.size()));
        for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
            check($sformatf("%s ar%0d", tag, i), 64'(ar_log[i]), 64'(exp_ar[i]));
        for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++)
            check($sformatf("%s aw%0d", tag, i), 64'(aw_log[i]), 64'(exp_aw[i]));
        for (int i = 0; i < int'(words); i++)
            check($sformatf("%s word%0d", tag, i), 64'(mem[dw + 32'(i)]), 64'(exp_data[i]));
        check({tag, " past end untouched"}, 64'(mem[dw + words]), 64'(32'hDEAD_BEEF));
    endtask

    initial begin
        int   cyc;
        int   ebeat;
        logic seen;
        rst_n = 1'b0; start = 1'b0;
        src_addr = '0; dst_addr = '0; byte_len = '0;
        repeat (3) @(negedge clk);
        check("reset done", 64'(done), 64'(1));
        check("reset err", 64'(err), 64'(0));
        check("reset valids",
              64'({axi.arvalid_o, axi.rready_o, axi.awvalid_o, axi.wvalid_o, axi.bready_o}),
              64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer(32'h0000_1000, 32'h0000_2000, 16'h0100, -1, "aligned");
        run_xfer(32'h0000_0FF8, 32'h0000_3000, 16'h0020, -1, "page");
        run_xfer(32'h0000_5000, 32'h0000_6000, 16'h0006, -1, "oneword");
        run_xfer(32'h0000_7000, 32'h0000_7800, 16'h0040, 5, "rresp");
        run_xfer(32'h0000_7000, 32'h0000_7800, 16'h0000, -1, "zerolen");

        for (int t = 0; t < 6; t++) begin
            ebeat = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 20)) : -1;
            run_xfer(32'h0000_8000 + $urandom_range(0, 4095), 32'h0001_0000 + $urandom_range(0, 4095),
                     16'($urandom_range(0, 96)), ebeat, $sformatf("rand%0d", t));
        end

        // Reset in the middle of a write burst.
        src_addr = 32'h0000_1000; dst_addr = 32'h0000_2000; byte_len = 16'h0100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 500) begin
            @(negedge clk);
            cyc++;
            seen = axi.wvalid_o;
        end
        check("midreset reached wdata", 64'(seen), 64'(1));
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midreset valids",
              64'({axi.arvalid_o, axi.rready_o, axi.awvalid_o, axi.wvalid_o, axi.bready_o}),
              64'(0));
        check("midreset done", 64'(done), 64'(1));
        check("midreset err", 64'(err), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_xfer(32'h0000_A000, 32'h0000_B000, 16'h0030, -1, "afterreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
